reg_scoreboard: RTL

//  Per-register pending-write scoreboard on the producer side of the operand-forwarding path.

---
 rtl/reg_scoreboard_if.sv | 45 ++++
 rtl/reg_scoreboard.sv | 106 ++++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID/EX/WB signal bundle for the pending-write scoreboard
// Stats signals exist only when SCOREBOARD_STATS_EN is defined.
interface reg_scoreboard_if #(
  parameter int NREGS = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_long_wr;
  logic             id_fire;
  logic             flush_ex;
  logic [4:0]       wb_rd;
  logic             wb_long_wr;
  logic             stall;
  logic [NREGS-1:0] busy_mask;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]      stall_cycles;
  logic [15:0]      waw_stalls;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_long_wr, id_fire,
    output flush_ex, wb_rd, wb_long_wr,
    input  stall, busy_mask, stall_cycles, waw_stalls
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_long_wr, id_fire,
    input  flush_ex, wb_rd, wb_long_wr,
    output stall, busy_mask, stall_cycles, waw_stalls
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_long_wr, id_fire,
    output flush_ex, wb_rd, wb_long_wr,
    input  stall, busy_mask
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_long_wr, id_fire,
    input  flush_ex, wb_rd, wb_long_wr,
    output stall, busy_mask
  );
`endif
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending long-latency write scoreboard with RAW/WAW stall
// Optional stall statistics counters are enabled by defining SCOREBOARD_STATS_EN.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input logic              clk,
  input logic              rst_n,
  reg_scoreboard_if.slave  sb
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [CNT_W:0]   up_w [NREGS];
  logic [CNT_W:0]   down_w [NREGS];
  logic [CNT_W:0]   diff_w [NREGS];
  logic [NREGS-1:0] underflow;
  logic [NREGS-1:0] busy;
  logic             ex_v_q, ex_v_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             fire_long, wb_clr, fl_clr;
  logic             raw1, raw2, waw_full, stall_w;

  assign fire_long = sb.id_fire & sb.id_long_wr & (sb.id_rd != 5'd0);
  assign wb_clr    = sb.wb_long_wr & (sb.wb_rd != 5'd0);
  assign fl_clr    = sb.flush_ex & ex_v_q;

  // Issue, WB retire and EX squash are netted per register; the result is clamped to [0, max].
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      up_w[r]      = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, (fire_long & (sb.id_rd == 5'(r)))};
      down_w[r]    = {{CNT_W{1'b0}}, (wb_clr & (sb.wb_rd == 5'(r)))}
                   + {{CNT_W{1'b0}}, (fl_clr & (ex_rd_q == 5'(r)))};
      diff_w[r]    = up_w[r] - down_w[r];
      underflow[r] = (up_w[r] < down_w[r]);
      cnt_d[r]     = diff_w[r][CNT_W-1:0];
      if (r == 0 || underflow[r]) begin
        cnt_d[r] = '0;
      end else if (diff_w[r] > {1'b0, CNT_MAX}) begin
        cnt_d[r] = CNT_MAX;
      end
      busy[r] = (r != 0) && (cnt_q[r] != '0);
    end
  end

  // Flush squashes only the entry already in EX; a same-cycle issue still occupies EX.
  assign ex_v_d  = fire_long;
  assign ex_rd_d = sb.id_rd;

  function automatic logic raw_hit(input logic use_s, input logic [4:0] s);
    return use_s && (s != 5'd0) && (cnt_q[s] != '0)
           && !(wb_clr && (sb.wb_rd == s) && (cnt_q[s] == CNT_ONE));
  endfunction

  assign raw1     = raw_hit(sb.id_use_rs1, sb.id_rs1);
  assign raw2     = raw_hit(sb.id_use_rs2, sb.id_rs2);
  assign waw_full = sb.id_long_wr && (sb.id_rd != 5'd0) && (cnt_q[sb.id_rd] == CNT_MAX)
                    && !(wb_clr && (sb.wb_rd == sb.id_rd));
  assign stall_w  = rst_n & sb.id_valid & (raw1 | raw2 | waw_full);

  assign sb.stall     = stall_w;
  assign sb.busy_mask = busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      ex_v_q  <= 1'b0;
      ex_rd_q <= 5'd0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      ex_v_q  <= ex_v_d;
      ex_rd_q <= ex_rd_d;
    end
  end

  // Retiring or squashing a write that was never tracked is a pipeline protocol error.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (underflow == '0);
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] waw_stalls_q, waw_stalls_d;

  assign stall_cycles_d = stall_w ? stall_cycles_q + 32'd1 : stall_cycles_q;
  assign waw_stalls_d   = (stall_w && waw_full && (waw_stalls_q != 16'hFFFF))
                          ? waw_stalls_q + 16'd1 : waw_stalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      waw_stalls_q   <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      waw_stalls_q   <= waw_stalls_d;
    end
  end

  assign sb.stall_cycles = stall_cycles_q;
  assign sb.waw_stalls   = waw_stalls_q;
`endif
endmodule
